// File: rtl/register_bank.sv
// 16-entry register file: R0 hardwired to zero, two combinational read ports plus a debug port,
// one synchronous write port, stack pointer resets to SP_INIT.
module register_bank #(
    parameter int                 DATA_W  = 32,
    parameter int                 SP_IDX  = 15,
    parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_03FC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_addr1,
    input  logic [3:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [1:15];

    // R0 has no storage, so a write to index 0 simply finds no register to update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < 16; k++) begin
                regs[k] <= (k == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_en && (wr_addr != 4'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see stored state only; no bypass from wr_data avoids a loop through the datapath
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        dbg_data = '0;
        if (rd_addr1 != 4'd0) rd_data1 = regs[rd_addr1];
        if (rd_addr2 != 4'd0) rd_data2 = regs[rd_addr2];
        if (dbg_addr != 4'd0) dbg_data = regs[dbg_addr];
    end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus pushes expected read values, a monitor pops and compares.
module tb_register_bank;

    localparam logic [31:0] SP_INIT = 32'h0000_03FC;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    register_bank #(
        .DATA_W (32),
        .SP_IDX (15),
        .SP_INIT(SP_INIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2),
        .rd_data1(rd_data1),
        .rd_data2(rd_data2),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    typedef struct {
        string       name;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  ad;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
    } exp_t;

    exp_t        expq[$];
    logic        chk_valid;
    int          tests;
    int          fails;
    logic [31:0] model [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural view of the register file: what every address should read right now
    task automatic modelReset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        model[15] = SP_INIT;
    endtask

    // One write-port cycle: drive at the falling edge, let the rising edge act, commit to the model
    task automatic applyStimulus(input logic en, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        if (en && rst_n && addr != 4'd0) model[addr] = data;
    endtask

    // Present read addresses, then hand the expected values to the monitor
    task automatic checkOutput(input string name, input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] ad);
        exp_t e;
        rd_addr1 = a1;
        rd_addr2 = a2;
        dbg_addr = ad;
        #1;
        e.name = name;
        e.a1 = a1; e.a2 = a2; e.ad = ad;
        e.e1 = model[a1]; e.e2 = model[a2]; e.ed = model[ad];
        expq.push_back(e);
        chk_valid = 1'b1;
        #1;
        chk_valid = 1'b0;
    endtask

    // Monitor: compares DUT read ports against popped expectations whenever a check is presented
    initial begin
        exp_t e;
        forever begin
            @(posedge chk_valid);
            while (expq.size() > 0) begin
                e = expq.pop_front();
                tests += 3;
                if (rd_data1 !== e.e1) begin
                    fails++;
                    $display("[TB] FAIL %s rd_data1[%0d] actual %h expected %h", e.name, e.a1, rd_data1, e.e1);
                end
                if (rd_data2 !== e.e2) begin
                    fails++;
                    $display("[TB] FAIL %s rd_data2[%0d] actual %h expected %h", e.name, e.a2, rd_data2, e.e2);
                end
                if (dbg_data !== e.ed) begin
                    fails++;
                    $display("[TB] FAIL %s dbg_data[%0d] actual %h expected %h", e.name, e.ad, dbg_data, e.ed);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        tests     = 0;
        fails     = 0;
        chk_valid = 1'b0;
        rst_n     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 32'h0;
        rd_addr1  = 4'd0;
        rd_addr2  = 4'd0;
        dbg_addr  = 4'd0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Asynchronous reset mid-cycle, checked before any clock edge occurs
        #7;
        rst_n = 1'b0;
        modelReset();
        checkOutput("reset_no_edge", 0, 15, 15);
        for (int i = 0; i < 16; i++) checkOutput("reset_dbg", 4'(i), 4'(15 - i), 4'(i));
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Write/readback on successive edges
        applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'd9, 32'h1234_5678);
        checkOutput("write_readback", 5, 9, 15);

        // R0 immunity
        applyStimulus(1'b1, 4'd0, 32'hFFFF_FFFF);
        checkOutput("r0_immune", 0, 5, 0);
        for (int i = 1; i < 16; i++) checkOutput("r0_others", 4'(i), 0, 4'(i));

        // Same-cycle read and write of R3: old value before the edge, new value after
        applyStimulus(1'b1, 4'd3, 32'h0000_0011);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_0022;
        checkOutput("same_cycle_pre", 3, 3, 3);
        @(posedge clk);
        #1;
        model[3] = 32'h0000_0022;
        checkOutput("same_cycle_post", 3, 0, 3);

        // wr_en low holds R7, including an unknown write address
        applyStimulus(1'b1, 4'd7, 32'h0000_0077);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd7, 32'hAAAA_AAAA);
            checkOutput("wr_en_low", 7, 3, 7);
        end
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 4'bxxxx; wr_data = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        for (int i = 1; i < 16; i++) checkOutput("x_addr_idle", 4'(i), 7, 4'(i));

        // Back-to-back writes: each value visible for exactly one cycle
        applyStimulus(1'b1, 4'd8, 32'h0000_0A01);
        checkOutput("b2b_first", 8, 8, 8);
        applyStimulus(1'b1, 4'd8, 32'h0000_0A02);
        checkOutput("b2b_second", 8, 8, 8);
        applyStimulus(1'b1, 4'd8, 32'h0000_0A03);
        checkOutput("b2b_last", 8, 8, 8);

        // Reset mid-operation: R15 returns to SP_INIT and the write on the reset edge is dropped
        applyStimulus(1'b1, 4'd15, 32'h0000_0100);
        checkOutput("sp_written", 15, 8, 15);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h5555_5555;
        #2;
        rst_n = 1'b0;
        modelReset();
        checkOutput("reset_mid_async", 15, 8, 4);
        @(posedge clk);
        #1;
        checkOutput("reset_write_dropped", 4, 15, 4);
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        rst_n = 1'b1;
        checkOutput("reset_release", 15, 5, 4);
        applyStimulus(1'b1, 4'd6, 32'hCAFE_F00D);
        checkOutput("first_write_after_release", 6, 15, 6);

        // Randomized traffic against the array model
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            checkOutput("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)));
        end
        wr_en = 1'b0;

        wait_cycles = 0;
        while (expq.size() > 0 && wait_cycles < 100) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (expq.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain pending %0d expected 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
